// File: rtl/window_filter_rgb.sv
// rtl/window_filter_rgb.sv - streaming N x N neighbourhood filter for packed multi-channel pixels
//
// Purpose:
//   Buffers N-1 image rows and forms a sliding N x N window for every accepted
//   pixel. Each channel is reduced independently: passthrough (window centre),
//   box mean, minimum (erode) or maximum (dilate). The active mode is latched on
//   an accepted start-of-frame beat. Only interior pixels are produced. The
//   output frame is (LINE_WIDTH-N+1) pixels wide.
//   Optional macro FILTER_THRESH_EN adds a threshold port and a binarising
//   register stage, which raises latency from 1 to 2 clocks.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   mode       in   0 pass, 1 mean, 2 min, 3 max (sampled on accepted SOF)
//   in_valid   in   data_in / in_sof qualifier
//   in_sof     in   first pixel of frame
//   data_in    in   packed pixel, channel 0 in LSBs
//   threshold  in   per-channel threshold (FILTER_THRESH_EN only)
//   out_valid  out  data_out holds a filtered pixel
//   data_out   out  filtered pixel, same packing as data_in

module window_filter_rgb #(
  parameter int CH         = 3,
  parameter int CH_WIDTH   = 8,
  parameter int LINE_WIDTH = 640,
  parameter int N          = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [CH*CH_WIDTH-1:0] data_in,
`ifdef FILTER_THRESH_EN
  input  logic [CH_WIDTH-1:0]    threshold,
`endif
  output logic                   out_valid,
  output logic [CH*CH_WIDTH-1:0] data_out
);

  localparam int PW = CH * CH_WIDTH;
  localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int YW = $clog2(N);
  localparam int SW = CH_WIDTH + $clog2(N * N);
  localparam int C  = N / 2;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MEAN = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_MAX  = 2'd3
  } mode_e;

  logic [XW-1:0] x_q, x_d, pos_x;
  logic [YW-1:0] y_q, y_d, pos_y;
  mode_e         mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] res_q, res_d, red;

  logic [PW-1:0] line_mem [N-1][LINE_WIDTH];
  logic [PW-1:0] col      [N];
  logic [PW-1:0] win_q    [N][N];
  logic [PW-1:0] win_d    [N][N];

  logic [SW-1:0]       acc;
  logic [CH_WIDTH-1:0] px, lo, hi;

  // Position of the current beat: an accepted SOF overrides the counters so the
  // SOF pixel itself lands at (0,0). y saturates at N-1; it only tracks fill.
  always_comb begin
    pos_x       = in_sof ? '0 : x_q;
    pos_y       = in_sof ? '0 : y_q;
    mode_d      = (in_valid && in_sof) ? mode_e'(mode) : mode_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      if (pos_x == XW'(LINE_WIDTH - 1)) begin
        x_d = '0;
        y_d = (pos_y == YW'(N - 1)) ? pos_y : pos_y + YW'(1);
      end else begin
        x_d = pos_x + XW'(1);
        y_d = pos_y;
      end
      out_valid_d = (pos_x >= XW'(N - 1)) && (pos_y == YW'(N - 1));
    end
  end

  // Incoming window column, top row first: line buffer k holds the pixel
  // k+1 rows above the newest one at the same x.
  always_comb begin
    col[N-1] = data_in;
    for (int k = 0; k < N - 1; k++) begin
      col[N-2-k] = line_mem[k][pos_x];
    end
  end

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][N-1] = col[r];
      end
    end
  end

  // Reduction runs on the window including the current beat so the result is
  // registered in the same cycle the pixel is accepted.
  always_comb begin
    red = '0;
    acc = '0;
    px  = '0;
    lo  = '0;
    hi  = '0;
    for (int ch = 0; ch < CH; ch++) begin
      acc = '0;
      lo  = '1;
      hi  = '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          px  = win_d[r][c][ch*CH_WIDTH +: CH_WIDTH];
          acc = acc + SW'(px);
          if (px < lo) lo = px;
          if (px > hi) hi = px;
        end
      end
      case (mode_d)
        MODE_PASS: red[ch*CH_WIDTH +: CH_WIDTH] = win_d[C][C][ch*CH_WIDTH +: CH_WIDTH];
        MODE_MEAN: red[ch*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'(acc / SW'(N * N));
        MODE_MIN:  red[ch*CH_WIDTH +: CH_WIDTH] = lo;
        default:   red[ch*CH_WIDTH +: CH_WIDTH] = hi;
      endcase
    end
    res_d = out_valid_d ? red : res_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= MODE_PASS;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      win_q       <= win_d;
    end
  end

  // Row buffers carry no reset; stale contents are never used because output
  // is gated by the fill counters.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < N - 1; k++) begin
        line_mem[k][pos_x] <= col[N-1-k];
      end
    end
  end

`ifdef FILTER_THRESH_EN
  logic          thr_valid_q, thr_valid_d;
  logic [PW-1:0] thr_q, thr_d;

  always_comb begin
    thr_valid_d = out_valid_q;
    thr_d       = thr_q;
    if (out_valid_q) begin
      for (int ch = 0; ch < CH; ch++) begin
        thr_d[ch*CH_WIDTH +: CH_WIDTH] =
          (res_q[ch*CH_WIDTH +: CH_WIDTH] >= threshold) ? {CH_WIDTH{1'b1}} : {CH_WIDTH{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_valid_q <= 1'b0;
      thr_q       <= '0;
    end else begin
      thr_valid_q <= thr_valid_d;
      thr_q       <= thr_d;
    end
  end

  assign out_valid = thr_valid_q;
  assign data_out  = thr_q;
`else
  assign out_valid = out_valid_q;
  assign data_out  = res_q;
`endif

endmodule

// File: tb/tb_window_filter_rgb.sv
// tb/tb_window_filter_rgb.sv - self-checking bench for window_filter_rgb

module tb_window_filter_rgb;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int LW = 5;
  localparam int N  = 3;
  localparam int PW = CH * CW;
`ifdef FILTER_THRESH_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] data_in = '0;
`ifdef FILTER_THRESH_EN
  logic [CW-1:0] threshold = 8'h03;
`endif
  logic          out_valid;
  logic [PW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  window_filter_rgb #(.CH(CH), .CH_WIDTH(CW), .LINE_WIDTH(LW), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .data_in  (data_in),
`ifdef FILTER_THRESH_EN
    .threshold(threshold),
`endif
    .out_valid(out_valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: whole-image store addressed by frame row/column.
  logic [PW-1:0] img [64][LW];
  int            mx = 0;
  int            mrow = 0;
  logic [1:0]    mmode = 2'd0;
  bit            ev_q [$];
  logic [PW-1:0] ed_q [$];
  int            nvalid;
  logic [PW-1:0] first_d;

  function automatic logic [PW-1:0] ref_pix(input int r, input int c);
    logic [PW-1:0] o;
    int v, sum, lo, hi;
    o = '0;
    for (int ch = 0; ch < CH; ch++) begin
      sum = 0; lo = 255; hi = 0;
      for (int dr = 0; dr < N; dr++) begin
        for (int dc = 0; dc < N; dc++) begin
          v = int'(img[(r - N + 1 + dr) & 63][c - N + 1 + dc][ch*CW +: CW]);
          sum += v;
          if (v < lo) lo = v;
          if (v > hi) hi = v;
        end
      end
      case (mmode)
        2'd0: v = int'(img[(r - N / 2) & 63][c - N / 2][ch*CW +: CW]);
        2'd1: v = sum / (N * N);
        2'd2: v = lo;
        default: v = hi;
      endcase
`ifdef FILTER_THRESH_EN
      v = (v >= int'(threshold)) ? 255 : 0;
`endif
      o[ch*CW +: CW] = CW'(v);
    end
    return o;
  endfunction

  // Called just after a falling edge: check the output due now, drive one beat,
  // record its expectation, advance to the next falling edge.
  task automatic cycle(input bit v, input bit s, input logic [PW-1:0] d);
    bit            ev;
    logic [PW-1:0] ed;
    if (ev_q.size() >= LAT) begin
      ev = ev_q.pop_front();
      ed = ed_q.pop_front();
      check("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (ev && out_valid) begin
        check("data_out", {8'b0, data_out}, {8'b0, ed});
        nvalid++;
        if (nvalid == 1) first_d = data_out;
      end
    end
    in_valid = v;
    in_sof   = s;
    data_in  = d;
    ev = 1'b0;
    ed = '0;
    if (v) begin
      if (s) begin
        mx = 0; mrow = 0; mmode = mode;
      end
      img[mrow & 63][mx] = d;
      ev = (mx >= N - 1) && (mrow >= N - 1);
      if (ev) ed = ref_pix(mrow, mx);
      mx++;
      if (mx == LW) begin
        mx = 0;
        mrow++;
      end
    end
    ev_q.push_back(ev);
    ed_q.push_back(ed);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'($urandom_range(0, 1)), PW'($urandom));
  endtask

  // kind: 0 constant 0x10, 1 ramp x*y, 2 random. vpat: 0 dense, 1 toggle, 2 random gaps.
  task automatic frame(input int npix, input logic [1:0] m, input logic [1:0] m_mid,
                       input int kind, input int vpat);
    logic [PW-1:0] d;
    int            px, py;
    nvalid  = 0;
    first_d = '0;
    mode    = m;
    for (int i = 0; i < npix; i++) begin
      px = i % LW;
      py = i / LW;
      if (i == 6) mode = m_mid;
      case (kind)
        0:       d = {CH{8'h10}};
        1:       d = {CH{8'(px * py)}};
        default: d = PW'($urandom);
      endcase
      if (vpat == 2 && $urandom_range(0, 2) == 0) idle();
      cycle(1'b1, i == 0, d);
      if (vpat == 1) idle();
    end
    repeat (LAT) idle();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {8'b0, data_out}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_valid_hold", {31'b0, out_valid}, 32'd0);
    end
    rst = 1'b1;
    ev_q.delete();
    ed_q.delete();
    mx = 0; mrow = 0; mmode = 2'd0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    frame(25, 2'd1, 2'd1, 0, 0);
    check("t1_count", nvalid, 32'd9);
`ifndef FILTER_THRESH_EN
    check("t1_first", {8'b0, first_d}, 32'h101010);

    frame(25, 2'd1, 2'd1, 1, 0);
    check("t2_mean", {8'b0, first_d}, 32'h010101);
    frame(25, 2'd3, 2'd3, 1, 0);
    check("t2_max", {8'b0, first_d}, 32'h040404);
    frame(25, 2'd2, 2'd2, 1, 0);
    check("t2_min", {8'b0, first_d}, 32'h000000);
    frame(25, 2'd0, 2'd0, 1, 0);
    check("t2_pass", {8'b0, first_d}, 32'h010101);

    frame(25, 2'd1, 2'd1, 1, 1);
    check("t3_count", nvalid, 32'd9);
    check("t3_first", {8'b0, first_d}, 32'h010101);
`else
    threshold = 8'h03;
    frame(25, 2'd3, 2'd3, 1, 0);
    check("t6_thr3", {8'b0, first_d}, 32'hFFFFFF);
    threshold = 8'h05;
    frame(25, 2'd3, 2'd3, 1, 0);
    check("t6_thr5", {8'b0, first_d}, 32'h000000);
    threshold = 8'h03;
`endif

    frame(8, 2'd1, 2'd1, 1, 0);
    @(negedge clk);
    do_reset();
    frame(25, 2'd1, 2'd1, 1, 0);
    check("t4_count", nvalid, 32'd9);

    frame(25, 2'd0, 2'd3, 1, 0);
    check("t5_count", nvalid, 32'd9);
`ifndef FILTER_THRESH_EN
    check("t5_pass", {8'b0, first_d}, 32'h010101);
    frame(25, 2'd3, 2'd3, 1, 0);
    check("t5_max", {8'b0, first_d}, 32'h040404);
`endif

    for (int f = 0; f < 12; f++) begin
`ifdef FILTER_THRESH_EN
      threshold = 8'($urandom);
`endif
      frame($urandom_range(8, 40), 2'($urandom), 2'($urandom), 2, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
